trivium: RTL and testbench
==========================

TRIVIUM -- requirements
Module: trivium

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port `clk`, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 Port `rst`, input, 1 bit: asynchronous active-low reset.
REQ-004 Port `init`, input, 1 bit: when high, loads the key and IV and starts warm-up.
REQ-005 Port `enable`, input, 1 bit: when high, keystream generation advances after warm-up.
REQ-006 Port `key`, input, 80 bits: secret key, sampled only while `init` is high.
REQ-007 Port `iv`, input, 80 bits: initialization vector, sampled only while `init` is high.
REQ-008 Port `keystream_bit`, output, 1 bit: registered keystream bit.
REQ-009 Port `ready`, output, 1 bit: warm-up complete; exists only under TRIVIUM_STATUS_EN.

Function
REQ-010 The block SHALL hold a 288-bit state s1..s288 and three modes: IDLE, WARMUP, RUN.
REQ-011 Load: s(i+1)=key[i] and s(94+i)=iv[i] for i=0..79; s286, s287 and s288 = 1; all other bits = 0.
REQ-012 A load SHALL set the mode to WARMUP, clear the round counter and clear `keystream_bit`.
REQ-013 Round definitions:
- t1=s66^s93, t2=s162^s177, t3=s243^s288;
- z=t1^t2^t3;
- t1'=t1^(s91&s92)^s171;
- t2'=t2^(s175&s176)^s264;
- t3'=t3^(s286&s287)^s69.
REQ-014 Shift per round: (s1..s93)<=(t3',s1..s92); (s94..s177)<=(t1',s94..s176); (s178..s288)<=(t2',s178..s287).
REQ-015 WARMUP rounds:
- exactly 1152 rounds, one per clock, independent of `enable`;
- z is discarded and `keystream_bit` stays 0;
- the mode becomes RUN after the 1152nd round.
REQ-016 RUN with `enable`=1: one round per clock, and `keystream_bit` <= z of the pre-update state (one-cycle latency).
REQ-017 RUN with `enable`=0: state and `keystream_bit` hold.
REQ-018 IDLE (after reset, before the first `init`): `enable` is ignored and the output stays 0.
REQ-019 `init` has priority over `enable` in every mode; `init` during WARMUP or RUN reloads and restarts warm-up.
REQ-020 A multi-cycle `init` SHALL reload on every cycle; warm-up counting begins on the first cycle with `init`=0.
REQ-021 The round counter SHALL be 11 bits wide, count 0..1151 and never wrap.

Reset
REQ-022 Asserting `rst` low SHALL asynchronously clear:
- the state to all zeros;
- the counter to 0;
- the mode to IDLE;
- `keystream_bit` to 0;
- `ready` to 0.
REQ-023 Reset mid-operation SHALL abandon the stream; a new `init` is then required.

Configuration
REQ-024 With macro TRIVIUM_STATUS_EN defined, the `ready` output SHALL exist and be 1 exactly in RUN mode.
REQ-025 Without TRIVIUM_STATUS_EN, the `ready` port SHALL be absent and all other behaviour is identical.

Structure
REQ-026 The shared package `trivium_pkg` SHALL hold:
- constants STATE_W=288, KEY_W=80, IV_W=80, WARMUP_ROUNDS=1152;
- the tap positions;
- the mode enum (IDLE, WARMUP, RUN).
REQ-027 The combinational round function (state in; next state and z out) SHALL be sub-module `trivium_round`, instantiated once.

Verification
REQ-028 Reset: with `rst`=0 and then released, without `init` and with `enable`=1 for 100 cycles -> `keystream_bit`=0 and `ready`=0 throughout.
REQ-029 Warm-up timing: key=80'h9719CFC92A9FF688F9AA, iv=80'hECBB76B09AFF71D0D151, one-cycle `init` -> `ready` rises exactly 1152 clocks later; `keystream_bit`=0 until then.
REQ-030 Known answer: the same key/IV with `enable`=1 -> the first 1000 output bits match a bit-exact software model of REQ-011..REQ-016.
REQ-031 Hold: drop `enable` for 20 cycles in RUN -> the output is frozen, and on re-enable the stream resumes with no bits skipped or duplicated (compare with the model).
REQ-032 Re-init: pulse `init` with the same key/IV at RUN bit 300 -> `ready`=0, and 1152 cycles later the stream restarts identical to its first run.
REQ-033 Async reset: assert `rst` mid-WARMUP between clock edges -> all outputs are 0 immediately, and a subsequent `init` yields the same stream as in the known-answer test.

Source files
------------

// File: rtl/trivium_pkg.sv
// Shared constants, tap positions and mode encoding for the Trivium keystream generator.
// State bit s(n) of the algorithm lives at vector index n-1 throughout.
package trivium_pkg;

  localparam int STATE_W       = 288;
  localparam int KEY_W         = 80;
  localparam int IV_W          = 80;
  localparam int WARMUP_ROUNDS = 1152;
  localparam int CNT_W         = 11;
  localparam int IV_OFS        = 93;

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(WARMUP_ROUNDS - 1);

  // Tap indices (0-based).
  localparam int T1_A = 65,  T1_B = 92,  T1_AND_A = 90,  T1_AND_B = 91,  T1_X = 170;
  localparam int T2_A = 161, T2_B = 176, T2_AND_A = 174, T2_AND_B = 175, T2_X = 263;
  localparam int T3_A = 242, T3_B = 287, T3_AND_A = 285, T3_AND_B = 286, T3_X = 68;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} mode_t;

  function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                    input logic [IV_W-1:0]  iv);
    logic [STATE_W-1:0] st;
    st                  = '0;
    st[KEY_W-1:0]       = key;
    st[IV_OFS +: IV_W]  = iv;
    st[STATE_W-1 -: 3]  = 3'b111;
    return st;
  endfunction

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium round: produces the shifted state and the output bit z.
module trivium_round
  import trivium_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] state_nxt,
  output logic               z
);

  logic t1, t2, t3, t1f, t2f, t3f;

  assign t1 = state[T1_A] ^ state[T1_B];
  assign t2 = state[T2_A] ^ state[T2_B];
  assign t3 = state[T3_A] ^ state[T3_B];
  assign z  = t1 ^ t2 ^ t3;

  assign t1f = t1 ^ (state[T1_AND_A] & state[T1_AND_B]) ^ state[T1_X];
  assign t2f = t2 ^ (state[T2_AND_A] & state[T2_AND_B]) ^ state[T2_X];
  assign t3f = t3 ^ (state[T3_AND_A] & state[T3_AND_B]) ^ state[T3_X];

  // Three shift registers of 93/84/111 bits, each fed by the feedback of another.
  assign state_nxt = {state[286:177], t2f, state[175:93], t1f, state[91:0], t3f};

endmodule

// File: rtl/trivium.sv
// Trivium keystream generator: load, 1152-round warm-up, then one bit per enabled clock.
// Optional TRIVIUM_STATUS_EN macro adds the `ready` status output.
module trivium
  import trivium_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             enable,
  input  logic [KEY_W-1:0] key,
  input  logic [IV_W-1:0]  iv,
  output logic             keystream_bit
`ifdef TRIVIUM_STATUS_EN
  ,
  output logic             ready
`endif
);

  mode_t              mode, mode_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [STATE_W-1:0] st, st_nxt, st_rnd;
  logic               z, ks_nxt;

  trivium_round u_round (
    .state     (st),
    .state_nxt (st_rnd),
    .z         (z)
  );

  always_comb begin
    mode_nxt = mode;
    cnt_nxt  = cnt;
    st_nxt   = st;
    ks_nxt   = keystream_bit;
    if (init) begin
      st_nxt   = load_state(key, iv);
      mode_nxt = WARMUP;
      cnt_nxt  = '0;
      ks_nxt   = 1'b0;
    end else begin
      case (mode)
        WARMUP: begin
          st_nxt = st_rnd;
          // Counter parks at the last round instead of wrapping.
          if (cnt == LAST_ROUND) mode_nxt = RUN;
          else                   cnt_nxt  = cnt + 1'b1;
        end
        RUN: begin
          if (enable) begin
            st_nxt = st_rnd;
            ks_nxt = z;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode          <= IDLE;
      cnt           <= '0;
      st            <= '0;
      keystream_bit <= 1'b0;
    end else begin
      mode          <= mode_nxt;
      cnt           <= cnt_nxt;
      st            <= st_nxt;
      keystream_bit <= ks_nxt;
    end
  end

`ifdef TRIVIUM_STATUS_EN
  assign ready = (mode == RUN);
`endif

endmodule

// File: tb/tb_trivium.sv
// Self-checking bench for trivium: bit-level reference model feeding a scoreboard queue,
// table-driven key/IV runs plus hand-written re-init and asynchronous-reset sequences.
module tb_trivium;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init = 1'b0;
  logic        enable = 1'b0;
  logic [79:0] key = '0;
  logic [79:0] iv = '0;
  logic        keystream_bit;
`ifdef TRIVIUM_STATUS_EN
  logic        ready;
`endif

  trivium dut (
    .clk           (clk),
    .rst           (rst),
    .init          (init),
    .enable        (enable),
    .key           (key),
    .iv            (iv),
    .keystream_bit (keystream_bit)
`ifdef TRIVIUM_STATUS_EN
    ,
    .ready         (ready)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [79:0] SPEC_KEY = 80'h9719CFC92A9FF688F9AA;
  localparam logic [79:0] SPEC_IV  = 80'hECBB76B09AFF71D0D151;

  typedef struct {
    logic [79:0] key;
    logic [79:0] iv;
    int          init_len;
    int          nbits;
    int          hold_at;
    int          hold_len;
    bit          save_ref;
    bit          cmp_ref;
  } vec_t;

  typedef struct {
    bit ks;
    bit rdy;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model, indexed s[1..288] as in the algorithm description.
  bit ms[1:288];
  int mmode;    // 0 idle, 1 warm-up, 2 run
  int mrounds;
  bit mks;
  bit ref_bits[1000];

  task automatic chk(input string nm, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %b want %b", nm, idx, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int j = 1; j <= 288; j++) ms[j] = 1'b0;
    mmode = 0; mrounds = 0; mks = 1'b0;
  endtask

  task automatic m_round(output bit z);
    bit t1, t2, t3;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 93; i > 1; i--)   ms[i] = ms[i-1];
    ms[1] = t3;
    for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
    ms[94] = t1;
    for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
    ms[178] = t2;
  endtask

  task automatic m_step(input bit i, input bit e);
    bit z;
    if (i) begin
      for (int j = 1; j <= 288; j++) ms[j] = 1'b0;
      for (int j = 0; j < 80; j++) begin
        ms[j+1]  = key[j];
        ms[94+j] = iv[j];
      end
      ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
      mmode = 1; mrounds = 0; mks = 1'b0;
    end else if (mmode == 1) begin
      m_round(z);
      mrounds++;
      if (mrounds == 1152) mmode = 2;
    end else if (mmode == 2 && e) begin
      m_round(z);
      mks = z;
    end
  endtask

  // Called at a falling edge: drive, predict, cross one rising edge, compare at next fall.
  task automatic tick(input bit i, input bit e);
    exp_t x;
    init = i;
    enable = e;
    if (!rst) m_reset();
    else      m_step(i, e);
    x.ks  = mks;
    x.rdy = (mmode == 2);
    exp_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1'b1, 1'b0);
    end else begin
      x = exp_q.pop_front();
      chk("ks", checks, keystream_bit, x.ks);
`ifdef TRIVIUM_STATUS_EN
      chk("ready", checks, ready, x.rdy);
`endif
    end
  endtask

  task automatic garble();
    key = {16'($urandom), $urandom, $urandom};
    iv  = {16'($urandom), $urandom, $urandom};
  endtask

  task automatic run_stream(input vec_t v);
    for (int c = 0; c < v.init_len; c++) begin
      if (c == v.init_len - 1) begin
        key = v.key;
        iv  = v.iv;
      end else begin
        garble();
      end
      tick(1'b1, 1'b1);
    end
    garble();
    for (int c = 0; c < 1152; c++) tick(1'b0, 1'($urandom_range(0, 1)));
    for (int k = 0; k < v.nbits; k++) begin
      if (k == v.hold_at)
        for (int h = 0; h < v.hold_len; h++) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      if (v.save_ref && k < 1000) ref_bits[k] = mks;
      if (v.cmp_ref && k < 1000) chk("ref_stream", k, keystream_bit, ref_bits[k]);
    end
  endtask

  // Drops reset between clock edges; outputs must clear without waiting for a clock.
  task automatic async_reset_mid();
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_ks", 0, keystream_bit, 1'b0);
`ifdef TRIVIUM_STATUS_EN
    chk("async_rst_ready", 0, ready, 1'b0);
`endif
    m_reset();
    @(negedge clk);
  endtask

  vec_t vecs[5];
  vec_t spec_v;

  initial begin
    vecs[0] = '{SPEC_KEY, SPEC_IV, 1, 1000, 400, 20, 1'b1, 1'b0};
    vecs[1] = '{80'h0, 80'h0, 1, 64, -1, 0, 1'b0, 1'b0};
    vecs[2] = '{{80{1'b1}}, {80{1'b1}}, 1, 64, 10, 5, 1'b0, 1'b0};
    vecs[3] = '{SPEC_KEY, SPEC_IV, 3, 300, -1, 0, 1'b0, 1'b1};
    vecs[4] = '{SPEC_KEY, SPEC_IV, 1, 200, 50, 7, 1'b0, 1'b1};
    spec_v  = '{SPEC_KEY, SPEC_IV, 1, 200, -1, 0, 1'b0, 1'b1};
    m_reset();

    #1;
    chk("por_ks", 0, keystream_bit, 1'b0);
    @(negedge clk);
    repeat (3) tick(1'b0, 1'b1);
    rst = 1'b1;

    // Idle: no init yet, enable ignored.
    for (int c = 0; c < 100; c++) begin
      garble();
      tick(1'b0, 1'b1);
    end

    // Vector 4 pulses init right at RUN bit 300 of vector 3.
    for (int v = 0; v < 5; v++) run_stream(vecs[v]);

    // Re-init in the middle of warm-up.
    key = vecs[1].key; iv = vecs[1].iv;
    tick(1'b1, 1'b0);
    for (int c = 0; c < 500; c++) tick(1'b0, 1'b1);
    run_stream(spec_v);

    // Async reset mid warm-up, then a clean restart.
    key = SPEC_KEY; iv = SPEC_IV;
    tick(1'b1, 1'b1);
    for (int c = 0; c < 300; c++) tick(1'b0, 1'b1);
    async_reset_mid();
    repeat (2) tick(1'b0, 1'b1);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) tick(1'b0, 1'b1);
    run_stream(spec_v);

    // Async reset in RUN while the output is high.
    for (int c = 0; c < 64 && !mks; c++) tick(1'b0, 1'b1);
    chk("run_high_before_rst", 0, keystream_bit, 1'b1);
    async_reset_mid();
    tick(1'b0, 1'b1);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) tick(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
